// File: rtl/conv_mac_engine_if.sv
// Start/done handshake between the traversal controller (master) and one
// convolution MAC lane (slave): 5x5 int8 window and kernel in, dot product out.
interface conv_mac_engine_if #(
    parameter int ACC_WIDTH = 32
);
    logic                        start;
    logic [4:0][4:0][7:0]        weights;
    logic [4:0][4:0][7:0]        inputs;
    logic signed [ACC_WIDTH-1:0] outputs;
    logic                        done;
    logic                        busy;

    modport master (
        output start, weights, inputs,
        input  outputs, done, busy
    );

    modport slave (
        input  start, weights, inputs,
        output outputs, done, busy
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Sequential 5x5 signed MAC: snapshots window and kernel on start, then
// accumulates one kernel row per cycle and pulses done with the result.

module conv_mac_row_dot (
    input  logic [4:0][7:0]     a,
    input  logic [4:0][7:0]     b,
    output logic signed [18:0]  sum
);
    logic signed [15:0] prod [5];

    for (genvar c = 0; c < 5; c++) begin : g_prod
        assign prod[c] = $signed(a[c]) * $signed(b[c]);
    end

    // Five 16-bit products need at most 19 bits signed, so no bits are lost.
    always_comb begin
        sum = '0;
        for (int c = 0; c < 5; c++) begin
            sum = sum + {{3{prod[c][15]}}, prod[c]};
        end
    end
endmodule

module conv_mac_engine #(
    parameter int ACC_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    conv_mac_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [4:0][4:0][7:0]        win;
    logic [4:0][4:0][7:0]        wgt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] result;
    logic [2:0]                  row;
    logic                        done_q;
    logic                        busy_q;
    logic signed [18:0]          row_sum;
    logic signed [ACC_WIDTH-1:0] row_ext;

    // Only the row selected by the counter is reduced each cycle.
    conv_mac_row_dot u_dot (
        .a   (win[row]),
        .b   (wgt[row]),
        .sum (row_sum)
    );

    assign row_ext = {{(ACC_WIDTH-19){row_sum[18]}}, row_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            win    <= '0;
            wgt    <= '0;
            acc    <= '0;
            result <= '0;
            row    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        win    <= bus.inputs;
                        wgt    <= bus.weights;
                        acc    <= '0;
                        row    <= '0;
                        busy_q <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + row_ext;
                    row <= row + 3'd1;
                    if (row == 3'd4) begin
                        result <= acc + row_ext;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a held start
                    // relaunches from IDLE one cycle later.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.outputs = result;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized and directed checks of conv_mac_engine against a plain-arithmetic
// dot-product model with cycle-accurate handshake expectations.
module tb_conv_mac_engine;
    typedef logic [4:0][4:0][7:0] win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    conv_mac_engine_if #(.ACC_WIDTH(32)) bus ();

    conv_mac_engine #(.ACC_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic win_t fill(input logic [7:0] v);
        win_t w;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r][c] = v;
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r][c] = 8'($urandom);
        return w;
    endfunction

    function automatic longint ref_dot(input win_t a, input win_t b);
        longint s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += longint'($signed(a[r][c])) * longint'($signed(b[r][c]));
        return s;
    endfunction

    // One start pulse; live data is replaced by wi_after and junk weights
    // right after the capture edge. Expects done 5 samples after the capture
    // edge, busy for 6 samples, and exactly one done pulse.
    task automatic run_op(input string tag, input win_t wi, input win_t wt,
                          input win_t wi_after, input longint exp);
        int     done_at = -1;
        int     ndone = 0;
        int     nbusy = 0;
        longint res = 0;
        bus.inputs  = wi;
        bus.weights = wt;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.inputs  = wi_after;
        bus.weights = rand_win();
        for (int i = 0; i < 8; i++) begin
            if (bus.done) begin
                ndone++;
                done_at = i;
                res = longint'(bus.outputs);
            end
            if (bus.busy) nbusy++;
            step();
        end
        chk({tag, "_result"}, res, exp);
        chk({tag, "_done_cnt"}, ndone, 1);
        chk({tag, "_done_lat"}, done_at, 5);
        chk({tag, "_busy_cyc"}, nbusy, 6);
        chk({tag, "_hold"}, longint'(bus.outputs), exp);
    endtask

    initial begin
        win_t   a, b;
        int     nd, t[3];
        longint v[3];
        int     extra;

        bus.start   = 1'b0;
        bus.inputs  = '0;
        bus.weights = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_outputs", longint'(bus.outputs), 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);

        run_op("ones", fill(8'sd1), fill(8'sd1), fill(8'sd1), 25);
        run_op("neg_neg", fill(8'h80), fill(8'h80), fill(8'h80), 409600);
        run_op("pos_neg", fill(8'd127), fill(8'h80), fill(8'd127), -406400);
        run_op("pos_pos", fill(8'd127), fill(8'd127), fill(8'd127), 403225);

        b = '0;
        b[2][2] = 8'd3;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                a[r][c] = 8'(r * 5 + c - 12);
        run_op("center_ramp", a, b, a, 0);
        a = fill(8'd50);
        a[2][2] = 8'($signed(-7));
        run_op("center_m7", a, b, a, -21);

        run_op("iso_first", fill(8'd1), fill(8'd2), fill(8'd100), 50);
        run_op("iso_second", fill(8'd100), fill(8'd2), fill(8'd100), 5000);

        // start held high across three operations
        bus.weights = fill(8'd1);
        bus.inputs  = fill(8'd1);
        bus.start   = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (bus.done) begin
                if (nd < 3) begin
                    t[nd] = cyc;
                    v[nd] = longint'(bus.outputs);
                end
                nd++;
                if (nd < 3) bus.inputs = fill(8'(nd + 1));
                else        bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", nd, 3);
        chk("b2b_res0", v[0], 25);
        chk("b2b_res1", v[1], 50);
        chk("b2b_res2", v[2], 75);
        chk("b2b_gap01", t[1] - t[0], 7);
        chk("b2b_gap12", t[2] - t[1], 7);

        // reset in the middle of an operation
        run_op("pre_rst", fill(8'd1), fill(8'd1), fill(8'd1), 25);
        bus.inputs  = fill(8'd9);
        bus.weights = fill(8'd9);
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_outputs", longint'(bus.outputs), 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done || bus.busy) extra++;
            step();
        end
        chk("abort_quiet", extra, 0);
        run_op("post_rst", fill(8'd1), fill(8'd1), fill(8'd1), 25);

        for (int k = 0; k < 20; k++) begin
            a = rand_win();
            b = rand_win();
            run_op($sformatf("rand%0d", k), a, b, rand_win(), ref_dot(a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
